// File: rtl/bus_arb_mux_pkg.sv
// Shared bus constants, source map and arbiter state type.
// Imported by the interface, the arbiter and the bus_arb_mux top.
package bus_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int BUS_NSRC  = 24;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_C      = 23;

    typedef enum logic {
        IDLE,
        OWNED
    } bus_state_t;

endpackage

// File: rtl/bus_arb_mux_if.sv
// Bus bundle between the register sources and the arbitrated bus.
// master = source side / bench, slave = bus_arb_mux.
interface bus_arb_mux_if
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = BUS_NSRC
) ();

    localparam int SELW = $clog2(NSRC);

    logic [NSRC-1:0]       req;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  lock;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [NSRC-1:0]       grant;
    logic [SELW-1:0]       grant_idx;

    modport master (
        output req, src_data, lock,
        input  bus_out, bus_valid, grant, grant_idx
    );

    modport slave (
        input  req, src_data, lock,
        output bus_out, bus_valid, grant, grant_idx
    );

endinterface

// File: rtl/bus_arb_mux_rr_arbiter.sv
// Round-robin request scan: first requester after rrPtr, wrapping.
// Purely combinational; the pointer lives in bus_arb_mux.
module rr_arbiter #(
    parameter int NSRC = 24,
    parameter int SELW = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [SELW-1:0] rrPtr,
    output logic [NSRC-1:0] winOneHot,
    output logic [SELW-1:0] winIdx,
    output logic            anyReq
);

    int              pos;
    logic [SELW-1:0] posIdx;

    // scan rrPtr+1 .. rrPtr (mod NSRC), keep the first hit
    always_comb begin
        winOneHot = '0;
        winIdx    = '0;
        anyReq    = 1'b0;
        pos       = 0;
        posIdx    = '0;
        for (int k = 1; k <= NSRC; k++) begin
            pos    = (int'(rrPtr) + k) % NSRC;
            posIdx = SELW'(pos);
            if (!anyReq && req[posIdx]) begin
                anyReq            = 1'b1;
                winIdx            = posIdx;
                winOneHot[posIdx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered round-robin arbitrated bus mux with optional bus lock.
// Define BUS_ARB_LOCK_EN to honour the lock input.
module bus_arb_mux
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = BUS_NSRC
) (
    input  logic          clock,
    input  logic          clear,
    bus_arb_mux_if.slave  bus
);

    localparam int SELW = $clog2(NSRC);

`ifdef BUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    bus_state_t      state;
    bus_state_t      stateNext;
    logic [SELW-1:0] rrPtr;
    logic [SELW-1:0] rrPtrNext;

    logic [WIDTH-1:0] busOutQ;
    logic [WIDTH-1:0] busOutNext;
    logic             busValidQ;
    logic             busValidNext;
    logic [NSRC-1:0]  grantQ;
    logic [NSRC-1:0]  grantNext;
    logic [SELW-1:0]  grantIdxQ;
    logic [SELW-1:0]  grantIdxNext;

    logic [NSRC-1:0]  winOneHot;
    logic [SELW-1:0]  winIdx;
    logic             anyReq;
    logic             hold;

    rr_arbiter #(
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_arb (
        .req       (bus.req),
        .rrPtr     (rrPtr),
        .winOneHot (winOneHot),
        .winIdx    (winIdx),
        .anyReq    (anyReq)
    );

    assign hold = LOCK_EN
               && (state == OWNED)
               && bus.lock
               && bus.req[grantIdxQ];

    // state register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // next state: stay owned while held or someone requests
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  stateNext = anyReq ? OWNED : IDLE;
            OWNED: stateNext = (hold || anyReq) ? OWNED : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // next register values: hold, re-arbitrate, or go idle
    always_comb begin
        busOutNext   = busOutQ;
        busValidNext = busValidQ;
        grantNext    = grantQ;
        grantIdxNext = grantIdxQ;
        rrPtrNext    = rrPtr;
        priority case (1'b1)
            hold: begin
                busOutNext =
                    bus.src_data[int'(grantIdxQ)*WIDTH +: WIDTH];
            end
            anyReq: begin
                busOutNext   =
                    bus.src_data[int'(winIdx)*WIDTH +: WIDTH];
                busValidNext = 1'b1;
                grantNext    = winOneHot;
                grantIdxNext = winIdx;
                rrPtrNext    = winIdx;
            end
            default: begin
                busValidNext = 1'b0;
                grantNext    = '0;
            end
        endcase
    end

    // bus, grant and pointer registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            busOutQ   <= '0;
            busValidQ <= 1'b0;
            grantQ    <= '0;
            grantIdxQ <= '0;
            rrPtr     <= SELW'(NSRC - 1);
        end else begin
            busOutQ   <= busOutNext;
            busValidQ <= busValidNext;
            grantQ    <= grantNext;
            grantIdxQ <= grantIdxNext;
            rrPtr     <= rrPtrNext;
        end
    end

    assign bus.bus_out   = busOutQ;
    assign bus.bus_valid = busValidQ;
    assign bus.grant     = grantQ;
    assign bus.grant_idx = grantIdxQ;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Randomised, model-checked bench for bus_arb_mux (24 x 32 bits).
// Lock expectations follow BUS_ARB_LOCK_EN.
module tb_bus_arb_mux;
    import bus_pkg::*;

    localparam int W = 32;
    localparam int N = 24;

`ifdef BUS_ARB_LOCK_EN
    localparam bit LOCKEN = 1'b1;
`else
    localparam bit LOCKEN = 1'b0;
`endif

    logic          clock;
    logic          clear;
    logic [N-1:0]  reqIn;
    logic          lockIn;
    logic [W-1:0]  srcVal [N];

    int total;
    int bad;

    logic [W-1:0] expBus;
    logic         expValid;
    logic [N-1:0] expGrant;
    int           expIdx;
    int           mPtr;
    bit           mOwned;

    bus_arb_mux_if #(.WIDTH(W), .NSRC(N)) bif ();

    bus_arb_mux #(.WIDTH(W), .NSRC(N)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bif)
    );

    assign bif.req  = reqIn;
    assign bif.lock = lockIn;

    always_comb begin
        bif.src_data = '0;
        for (int i = 0; i < N; i++)
            bif.src_data[i*W +: W] = srcVal[i];
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [61:0] obs();
        return {bif.bus_valid, bif.grant,
                bif.grant_idx, bif.bus_out};
    endfunction

    function automatic logic [61:0] expv();
        logic [4:0] ix;
        ix = 5'(expIdx);
        return {expValid, expGrant, ix, expBus};
    endfunction

    task automatic modelReset();
        expBus   = '0;
        expValid = 1'b0;
        expGrant = '0;
        expIdx   = 0;
        mPtr     = N - 1;
        mOwned   = 1'b0;
    endtask

    // one edge of the reference rules
    task automatic modelStep();
        int  win;
        if (!clear) begin
            modelReset();
            return;
        end
        if (LOCKEN && mOwned && lockIn && reqIn[expIdx]) begin
            expBus = srcVal[expIdx];
            return;
        end
        win = -1;
        for (int k = 1; k <= N; k++) begin
            if (win < 0 && reqIn[(mPtr + k) % N])
                win = (mPtr + k) % N;
        end
        if (win >= 0) begin
            expGrant = '0;
            expGrant[win] = 1'b1;
            expIdx   = win;
            expBus   = srcVal[win];
            expValid = 1'b1;
            mPtr     = win;
            mOwned   = 1'b1;
        end else begin
            expValid = 1'b0;
            expGrant = '0;
            mOwned   = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        #3;
        clear = 1'b0;
        #1;
        modelReset();
        total++;
        if (obs() !== 62'd0) begin
            bad++;
            $display("FAIL reset_async got=%h want=0", obs());
        end
        @(negedge clock);
        clear = 1'b1;
        tick();
        total++;
        if (obs() !== expv() || bif.grant_idx !== 5'd0) begin
            bad++;
            $display("FAIL reset_first got=%h want=%h",
                     obs(), expv());
        end
        tick();
        tick();
        total++;
        if (bif.grant_idx !== 5'd2 || obs() !== expv()) begin
            bad++;
            $display("FAIL pre_midreset got=%h want=%h",
                     obs(), expv());
        end
        @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        modelReset();
        total++;
        if (obs() !== 62'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0", obs());
        end
        @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic test_fairness();
        logic [W-1:0] want;
        reqIn  = '1;
        lockIn = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            want = 32'h01010101 * (k % N);
            total++;
            if (obs() !== expv()
                || int'(bif.grant_idx) != k % N
                || bif.bus_out !== want) begin
                bad++;
                $display("FAIL fair_%0d got=%h want=%h",
                         k, obs(), expv());
            end
        end
    endtask

    task automatic test_lock();
        int           wIdx;
        logic [W-1:0] wBus;
        @(negedge clock);
        reqIn = 24'h000008;
        tick();
        total++;
        if (bif.grant_idx !== 5'd3 || obs() !== expv()) begin
            bad++;
            $display("FAIL lock_setup got=%h want=%h",
                     obs(), expv());
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            reqIn     = '1;
            lockIn    = 1'b1;
            srcVal[3] = 32'hDEADBEEF;
            tick();
            wIdx = LOCKEN ? 3 : 4 + k;
            wBus = LOCKEN ? 32'hDEADBEEF : 32'h01010101 * wIdx;
            total++;
            if (obs() !== expv()
                || int'(bif.grant_idx) != wIdx
                || bif.bus_out !== wBus) begin
                bad++;
                $display("FAIL lock_hold_%0d got=%h want=%h",
                         k, obs(), expv());
            end
        end
        @(negedge clock);
        lockIn = 1'b0;
        tick();
        wIdx = LOCKEN ? 4 : 8;
        total++;
        if (obs() !== expv() || int'(bif.grant_idx) != wIdx) begin
            bad++;
            $display("FAIL lock_release got=%h want=%h",
                     obs(), expv());
        end
        srcVal[3] = 32'h03030303;
    endtask

    task automatic test_owner_drop();
        int           wIdx;
        logic [W-1:0] last;
        @(negedge clock);
        reqIn  = 24'h000008;
        lockIn = 1'b0;
        tick();
        @(negedge clock);
        reqIn  = 24'h000208;
        lockIn = 1'b1;
        tick();
        wIdx = LOCKEN ? 3 : 9;
        total++;
        if (obs() !== expv() || int'(bif.grant_idx) != wIdx) begin
            bad++;
            $display("FAIL drop_hold got=%h want=%h",
                     obs(), expv());
        end
        @(negedge clock);
        reqIn = 24'h001200;
        tick();
        wIdx = LOCKEN ? 9 : 12;
        total++;
        if (obs() !== expv() || int'(bif.grant_idx) != wIdx
            || bif.bus_valid !== 1'b1) begin
            bad++;
            $display("FAIL drop_rearb got=%h want=%h",
                     obs(), expv());
        end
        last = 32'h01010101 * wIdx;
        @(negedge clock);
        reqIn = '0;
        tick();
        total++;
        if (obs() !== expv() || bif.bus_valid !== 1'b0
            || bif.grant !== 24'h0 || bif.bus_out !== last) begin
            bad++;
            $display("FAIL drop_idle got=%h want=%h",
                     obs(), expv());
        end
    endtask

    task automatic test_single();
        @(negedge clock);
        reqIn  = 24'h000020;
        lockIn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (obs() !== expv() || bif.bus_valid !== 1'b1
                || bif.grant !== 24'h000020
                || bif.bus_out !== 32'h05050505) begin
                bad++;
                $display("FAIL single_%0d got=%h want=%h",
                         k, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            r = $urandom;
            case ($urandom_range(0, 3))
                0: reqIn = '0;
                1: reqIn = r[23:0];
                2: reqIn = r[23:0] & 24'($urandom);
                default: reqIn = 24'd1 << $urandom_range(0, N-1);
            endcase
            lockIn = 1'($urandom_range(0, 1));
            srcVal[$urandom_range(0, N-1)] = $urandom;
            srcVal[$urandom_range(0, N-1)] = $urandom;
            tick();
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL rand_%0d got=%h want=%h",
                         k, obs(), expv());
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        clear  = 1'b1;
        reqIn  = '1;
        lockIn = 1'b0;
        for (int i = 0; i < N; i++)
            srcVal[i] = 32'h01010101 * i;
        modelReset();
        test_reset();
        test_fairness();
        test_lock();
        test_owner_drop();
        test_single();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
